stride_counter: RTL and testbench
=================================

# stride_counter

Parametrised, registered stride counter: a WIDTH-bit counter that steps by a runtime stride, counts up or down, wraps modulo a runtime upper bound, and supports synchronous load and enable. Reset value and default stride reproduce the team's existing odd-sequence counter (1, 3, 5, …). It serves as the general sequence/index generator for address walkers, test-pattern sources and interleaved-channel selectors.

## Interface
- WIDTH, 8: counter, stride and bound width (≥2)
- INIT, 1: value of cnt_o after reset (must be < 2^WIDTH)
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- en_i  input  1  advance counter by one stride this cycle
- load_i  input  1  load load_val_i this cycle (overrides en_i)
- load_val_i  input  WIDTH  value to load
- step_i  input  WIDTH  stride magnitude
- dir_i  input  1  0 = count up, 1 = count down
- max_i  input  WIDTH  inclusive upper bound; count range is 0..max_i (modulus max_i+1)
- cnt_o  output  WIDTH  registered count
- wrap_o  output  1  registered; high for one cycle with the cnt_o value produced by a wrapping step
- err_o  output  1  registered; high for one cycle with cnt_o when a step was rejected

## Operation
- Priority per cycle: reset > load_i > en_i > hold.
- Reset: cnt_o = INIT, wrap_o = 0, err_o = 0. INIT is not checked against max_i.
- Load: cnt_o = min(load_val_i, max_i); wrap_o = 0, err_o = 0.
- Hold (en_i = 0, no load): cnt_o unchanged; wrap_o = 0, err_o = 0.
- Step, all arithmetic in WIDTH+1 bits, M = max_i + 1:
  - step_i > max_i: step rejected, cnt_o holds, err_o = 1.
  - cnt_o > max_i (bound lowered mid-run): cnt_o = 0 if up, max_i if down; wrap_o = 1.
  - up: s = cnt_o + step_i; s ≤ max_i → cnt_o = s; else cnt_o = s − M, wrap_o = 1.
  - down: cnt_o ≥ step_i → cnt_o = cnt_o − step_i; else cnt_o = cnt_o + M − step_i, wrap_o = 1.
- step_i = 0 with en_i: legal, cnt_o holds, no flags.
- max_i = 2^WIDTH−1: plain modulo-2^WIDTH counting, no overflow of the WIDTH+1 intermediate.
- step_i, dir_i and max_i are sampled every cycle; changing any of them between steps is legal.

## Timing
- All outputs registered; one-cycle latency from sampled inputs to cnt_o/wrap_o/err_o.
- wrap_o and err_o are single-cycle pulses aligned with the cnt_o value they describe; back-to-back wrapping steps give wrap_o high on consecutive cycles.
- reset asserted mid-sequence takes effect at the next edge regardless of load_i/en_i.
- No combinational input-to-output paths.

## Configuration
- STRIDE_COUNTER_SAT_EN defined: saturating mode. An up step that would exceed max_i sets cnt_o = max_i; a down step that would go below 0 sets cnt_o = 0. wrap_o pulses on every step that was clamped, including repeated steps while already pinned at the bound. The out-of-range (cnt_o > max_i) case sets cnt_o = max_i for both directions. Reject rule (step_i > max_i → err_o) unchanged.
- Not defined: modular wrap behaviour as described under Operation.

## Test plan
- Reset then en_i=1, step_i=2, dir_i=0, max_i=255 for 130 cycles → cnt_o 1, 3, 5, …, 253, 255, 1; wrap_o high only on the 255→1 transition.
- load_i=1, load_val_i=3, then en_i=1, step_i=4, dir_i=1, max_i=9 → cnt_o 3, 9, 5, 1, 7; wrap_o high with 9 and 7.
- load_val_i=200 with max_i=99 → cnt_o=99. Then max_i lowered to 50 and up step → cnt_o=0, wrap_o=1.
- step_i=12 with max_i=9, en_i=1 → cnt_o unchanged, err_o=1 for that cycle only. load_i and en_i both high → load wins.
- Reset asserted together with load_i and en_i mid-count → cnt_o=INIT, wrap_o=0, err_o=0 next cycle.
- With STRIDE_COUNTER_SAT_EN, up, step_i=3, max_i=10, from 0 → cnt_o 3, 6, 9, 10, 10; wrap_o high with both 10s. Down from 2, step_i=3 → cnt_o=0, wrap_o=1.

Source files
------------

// File: rtl/stride_counter.sv
// Registered stride counter: steps up/down by step_i, wraps modulo max_i+1, sync load/enable.
// Optional STRIDE_COUNTER_SAT_EN selects saturating (clamp-at-bound) stepping instead of wrapping.
module stride_counter #(
  parameter int WIDTH = 8,
  parameter int INIT  = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic [WIDTH-1:0] step_i,
  input  logic             dir_i,
  input  logic [WIDTH-1:0] max_i,
  output logic [WIDTH-1:0] cnt_o,
  output logic             wrap_o,
  output logic             err_o
);

  localparam logic [WIDTH-1:0] INIT_V = WIDTH'(INIT);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             wrap_q, wrap_d;
  logic             err_q, err_d;

  // One extra bit so that sums and the max_i=2^WIDTH-1 modulus never overflow.
  logic [WIDTH:0] cnt_x, step_x, max_x, mod_x, sum_x, fold_x;

  assign cnt_x  = {1'b0, cnt_q};
  assign step_x = {1'b0, step_i};
  assign max_x  = {1'b0, max_i};
  assign mod_x  = max_x + 1'b1;
  assign sum_x  = cnt_x + step_x;
  assign fold_x = dir_i ? (cnt_x + mod_x - step_x) : (sum_x - mod_x);

  always_comb begin
    cnt_d  = cnt_q;
    wrap_d = 1'b0;
    err_d  = 1'b0;
    if (load_i) begin
      cnt_d = (load_val_i > max_i) ? max_i : load_val_i;
    end else if (en_i) begin
      if (step_i > max_i) begin
        err_d = 1'b1;
      end else if (cnt_q > max_i) begin
        wrap_d = 1'b1;
`ifdef STRIDE_COUNTER_SAT_EN
        cnt_d  = max_i;
`else
        cnt_d  = dir_i ? max_i : '0;
`endif
      end else if (!dir_i) begin
        if (sum_x <= max_x) begin
          cnt_d = sum_x[WIDTH-1:0];
        end else begin
          wrap_d = 1'b1;
`ifdef STRIDE_COUNTER_SAT_EN
          cnt_d  = max_i;
`else
          cnt_d  = fold_x[WIDTH-1:0];
`endif
        end
      end else begin
        if (cnt_q >= step_i) begin
          cnt_d = cnt_q - step_i;
        end else begin
          wrap_d = 1'b1;
`ifdef STRIDE_COUNTER_SAT_EN
          cnt_d  = '0;
`else
          cnt_d  = fold_x[WIDTH-1:0];
`endif
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= INIT_V;
      wrap_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      wrap_q <= wrap_d;
      err_q  <= err_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign wrap_o = wrap_q;
  assign err_o  = err_q;

endmodule

// File: tb/tb_stride_counter.sv
// Self-checking bench for stride_counter: directed scenarios plus randomized traffic
// against an integer-arithmetic reference model.
module tb_stride_counter;
  localparam int W    = 8;
  localparam int INIT = 1;
`ifdef STRIDE_COUNTER_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset, en_i, load_i, dir_i;
  logic [W-1:0] load_val_i, step_i, max_i;
  logic [W-1:0] cnt_o;
  logic         wrap_o, err_o;

  int checks = 0;
  int failures = 0;
  int m_cnt;
  bit m_wrap, m_err;

  stride_counter #(.WIDTH(W), .INIT(INIT)) dut (
    .clk(clk), .reset(reset), .en_i(en_i), .load_i(load_i),
    .load_val_i(load_val_i), .step_i(step_i), .dir_i(dir_i), .max_i(max_i),
    .cnt_o(cnt_o), .wrap_o(wrap_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  // Reference model: plain modular / clamped integer arithmetic on the current count.
  task automatic cyc(input bit rst, input bit ld, input int lv, input bit en,
                     input int st, input bit dn, input int mx);
    int m;
    reset = rst; load_i = ld; en_i = en; dir_i = dn;
    load_val_i = lv[W-1:0]; step_i = st[W-1:0]; max_i = mx[W-1:0];
    m = mx + 1;
    m_wrap = 0; m_err = 0;
    if (rst) m_cnt = INIT;
    else if (ld) m_cnt = (lv < mx) ? lv : mx;
    else if (en) begin
      if (st > mx) m_err = 1;
      else if (m_cnt > mx) begin
        m_wrap = 1;
        m_cnt = (SAT || dn) ? mx : 0;
      end else if (!dn) begin
        m_wrap = (m_cnt + st) > mx;
        m_cnt = (SAT && m_wrap) ? mx : (m_cnt + st) % m;
      end else begin
        m_wrap = m_cnt < st;
        m_cnt = (SAT && m_wrap) ? 0 : (m_cnt - st + m) % m;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    cyc(1, 0, 0, 0, 0, 0, 255);
    cyc(1, 0, 0, 0, 0, 0, 255);
    checks++;
    if (cnt_o !== 8'd1 || wrap_o !== 1'b0 || err_o !== 1'b0) begin
      failures++;
      $display("FAIL reset cnt=%0d wrap=%0b err=%0b expected cnt=1 wrap=0 err=0", cnt_o, wrap_o, err_o);
    end
  endtask

  task automatic test_odd_sequence;
    for (int k = 1; k <= 130; k++) begin
      cyc(0, 0, 0, 1, 2, 0, 255);
      checks++;
      if (cnt_o !== m_cnt[W-1:0] || wrap_o !== m_wrap || err_o !== m_err) begin
        failures++;
        $display("FAIL odd_seq_model k=%0d cnt=%0d/%0d wrap=%0b/%0b err=%0b/%0b", k, cnt_o, m_cnt, wrap_o, m_wrap, err_o, m_err);
      end
`ifndef STRIDE_COUNTER_SAT_EN
      checks++;
      if (cnt_o !== 8'((1 + 2 * k) % 256) || wrap_o !== (k == 128)) begin
        failures++;
        $display("FAIL odd_seq k=%0d cnt=%0d wrap=%0b expected cnt=%0d wrap=%0b", k, cnt_o, wrap_o, (1 + 2 * k) % 256, k == 128);
      end
`endif
    end
  endtask

  task automatic test_down_wrap;
    int exp_c [5] = '{3, 9, 5, 1, 7};
    bit exp_w [5] = '{0, 1, 0, 0, 1};
    cyc(0, 1, 3, 0, 4, 1, 9);
    for (int k = 0; k < 5; k++) begin
      if (k > 0) cyc(0, 0, 0, 1, 4, 1, 9);
      checks++;
      if (cnt_o !== m_cnt[W-1:0] || wrap_o !== m_wrap || err_o !== m_err) begin
        failures++;
        $display("FAIL down_model k=%0d cnt=%0d/%0d wrap=%0b/%0b", k, cnt_o, m_cnt, wrap_o, m_wrap);
      end
`ifndef STRIDE_COUNTER_SAT_EN
      checks++;
      if (cnt_o !== 8'(exp_c[k]) || wrap_o !== exp_w[k]) begin
        failures++;
        $display("FAIL down_wrap k=%0d cnt=%0d wrap=%0b expected cnt=%0d wrap=%0b", k, cnt_o, wrap_o, exp_c[k], exp_w[k]);
      end
`endif
    end
  endtask

  task automatic test_load_clamp;
    cyc(0, 1, 200, 0, 1, 0, 99);
    checks++;
    if (cnt_o !== 8'd99 || wrap_o !== 1'b0 || err_o !== 1'b0) begin
      failures++;
      $display("FAIL load_clamp cnt=%0d wrap=%0b err=%0b expected cnt=99 wrap=0 err=0", cnt_o, wrap_o, err_o);
    end
    cyc(0, 0, 0, 1, 1, 0, 50);
    checks++;
    if (cnt_o !== (SAT ? 8'd50 : 8'd0) || wrap_o !== 1'b1 || err_o !== 1'b0) begin
      failures++;
      $display("FAIL bound_lowered cnt=%0d wrap=%0b err=%0b expected cnt=%0d wrap=1", cnt_o, wrap_o, err_o, SAT ? 50 : 0);
    end
  endtask

  task automatic test_reject;
    cyc(0, 1, 5, 0, 0, 0, 9);
    cyc(0, 0, 0, 1, 12, 0, 9);
    checks++;
    if (cnt_o !== 8'd5 || err_o !== 1'b1 || wrap_o !== 1'b0) begin
      failures++;
      $display("FAIL reject cnt=%0d err=%0b wrap=%0b expected cnt=5 err=1 wrap=0", cnt_o, err_o, wrap_o);
    end
    cyc(0, 0, 0, 1, 0, 0, 9);
    checks++;
    if (cnt_o !== 8'd5 || err_o !== 1'b0 || wrap_o !== 1'b0) begin
      failures++;
      $display("FAIL reject_pulse cnt=%0d err=%0b wrap=%0b expected cnt=5 err=0 wrap=0", cnt_o, err_o, wrap_o);
    end
    cyc(0, 1, 2, 1, 3, 0, 9);
    checks++;
    if (cnt_o !== 8'd2 || err_o !== 1'b0 || wrap_o !== 1'b0) begin
      failures++;
      $display("FAIL load_over_en cnt=%0d expected 2", cnt_o);
    end
  endtask

  task automatic test_reset_mid;
    cyc(0, 0, 0, 1, 7, 0, 20);
    cyc(0, 0, 0, 1, 7, 0, 20);
    cyc(1, 1, 9, 1, 7, 0, 20);
    checks++;
    if (cnt_o !== 8'(INIT) || wrap_o !== 1'b0 || err_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid cnt=%0d wrap=%0b err=%0b expected cnt=%0d wrap=0 err=0", cnt_o, wrap_o, err_o, INIT);
    end
  endtask

`ifdef STRIDE_COUNTER_SAT_EN
  task automatic test_saturate;
    int exp_c [5] = '{3, 6, 9, 10, 10};
    bit exp_w [5] = '{0, 0, 0, 1, 1};
    cyc(0, 1, 0, 0, 3, 0, 10);
    for (int k = 0; k < 5; k++) begin
      cyc(0, 0, 0, 1, 3, 0, 10);
      checks++;
      if (cnt_o !== 8'(exp_c[k]) || wrap_o !== exp_w[k]) begin
        failures++;
        $display("FAIL sat_up k=%0d cnt=%0d wrap=%0b expected cnt=%0d wrap=%0b", k, cnt_o, wrap_o, exp_c[k], exp_w[k]);
      end
    end
    cyc(0, 1, 2, 0, 3, 1, 10);
    cyc(0, 0, 0, 1, 3, 1, 10);
    checks++;
    if (cnt_o !== 8'd0 || wrap_o !== 1'b1) begin
      failures++;
      $display("FAIL sat_down cnt=%0d wrap=%0b expected cnt=0 wrap=1", cnt_o, wrap_o);
    end
  endtask
`endif

  task automatic test_random;
    int mx, st, lv;
    bit rst, ld, en;
    for (int k = 0; k < 400; k++) begin
      mx  = ($urandom_range(0, 4) == 0) ? 255 : $urandom_range(1, 40);
      st  = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 255) : $urandom_range(0, mx);
      lv  = $urandom_range(0, 255);
      rst = ($urandom_range(0, 49) == 0);
      ld  = ($urandom_range(0, 9) == 0);
      en  = ($urandom_range(0, 4) != 0);
      cyc(rst, ld, lv, en, st, 1'($urandom_range(0, 1)), mx);
      checks++;
      if (cnt_o !== m_cnt[W-1:0] || wrap_o !== m_wrap || err_o !== m_err) begin
        failures++;
        $display("FAIL random k=%0d cnt=%0d/%0d wrap=%0b/%0b err=%0b/%0b", k, cnt_o, m_cnt, wrap_o, m_wrap, err_o, m_err);
      end
    end
  endtask

  initial begin
    reset = 1; en_i = 0; load_i = 0; dir_i = 0;
    load_val_i = '0; step_i = '0; max_i = '1;
    m_cnt = INIT; m_wrap = 0; m_err = 0;
    test_reset();
    test_odd_sequence();
    test_down_wrap();
    test_load_clamp();
    test_reject();
    test_reset_mid();
`ifdef STRIDE_COUNTER_SAT_EN
    test_saturate();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
